// File: rtl/reg_access_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | reg_access_seq_pkg : shared widths, timeout default and sequencer states   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package reg_access_seq_pkg;

    localparam int DEF_WORD_WIDTH   = 16;
    localparam int DEF_NIB_WIDTH    = 4;
    localparam int DEF_EXEC_TIMEOUT = 15;

    typedef enum logic [2:0] {
        RAS_IDLE = 3'd0,
        RAS_RD_A = 3'd1,
        RAS_RD_B = 3'd2,
        RAS_EXEC = 3'd3,
        RAS_WB   = 3'd4,
        RAS_DONE = 3'd5
    } ras_state_e;

endpackage : reg_access_seq_pkg

`default_nettype wire

// File: rtl/reg_access_seq.sv
// +----------------------------------------------------------------------------+
// | reg_access_seq : reads operands, waits for the datapath, writes back       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_access_seq
    import reg_access_seq_pkg::*;
#(
    parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int NIB_WIDTH    = DEF_NIB_WIDTH,
    parameter int EXEC_TIMEOUT = DEF_EXEC_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  do_reset_n,
    input  logic                  start,
    input  logic                  rd_a_en,
    input  logic [NIB_WIDTH-1:0]  rd_a_num,
    input  logic                  rd_b_en,
    input  logic [NIB_WIDTH-1:0]  rd_b_num,
    input  logic                  wr_en,
    input  logic [NIB_WIDTH-1:0]  wr_num,
    input  logic                  result_valid,
    input  logic [WORD_WIDTH-1:0] result,
    input  logic [WORD_WIDTH-1:0] regout,
    output logic [NIB_WIDTH-1:0]  regnum,
    output logic [WORD_WIDTH-1:0] regval,
    output logic                  regset,
    output logic [WORD_WIDTH-1:0] opa,
    output logic [WORD_WIDTH-1:0] opb,
    output logic                  ops_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

    localparam logic [NIB_WIDTH-1:0] c_tmo_last = NIB_WIDTH'(EXEC_TIMEOUT - 1);

    ras_state_e            state_q, state_d;
    logic                  b_en_q, b_en_d;
    logic                  wr_en_q, wr_en_d;
    logic [NIB_WIDTH-1:0]  a_num_q, a_num_d;
    logic [NIB_WIDTH-1:0]  b_num_q, b_num_d;
    logic [NIB_WIDTH-1:0]  wr_num_q, wr_num_d;
    logic [WORD_WIDTH-1:0] opa_q, opa_d;
    logic [WORD_WIDTH-1:0] opb_q, opb_d;
    logic [WORD_WIDTH-1:0] res_q, res_d;
    logic [NIB_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;

    always_ff @(posedge clk or negedge do_reset_n) begin
        if (!do_reset_n) begin
            state_q   <= RAS_IDLE;
            b_en_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            a_num_q   <= '0;
            b_num_q   <= '0;
            wr_num_q  <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            b_en_q    <= b_en_d;
            wr_en_q   <= wr_en_d;
            a_num_q   <= a_num_d;
            b_num_q   <= b_num_d;
            wr_num_q  <= wr_num_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobes and the stack address depend only on state and latched fields.
    always_comb begin
        state_d   = state_q;
        b_en_d    = b_en_q;
        wr_en_d   = wr_en_q;
        a_num_d   = a_num_q;
        b_num_d   = b_num_q;
        wr_num_d  = wr_num_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        regnum    = '0;
        regval    = '0;
        regset    = 1'b0;
        ops_valid = 1'b0;
        done      = 1'b0;

        case (state_q)
            RAS_IDLE: begin
                if (start) begin
                    b_en_d    = rd_b_en;
                    wr_en_d   = wr_en;
                    a_num_d   = rd_a_num;
                    b_num_d   = rd_b_num;
                    wr_num_d  = wr_num;
                    opa_d     = '0;
                    opb_d     = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    if (rd_a_en)      state_d = RAS_RD_A;
                    else if (rd_b_en) state_d = RAS_RD_B;
                    else              state_d = RAS_EXEC;
                end
            end
            RAS_RD_A: begin
                regnum  = a_num_q;
                opa_d   = regout;
                state_d = b_en_q ? RAS_RD_B : RAS_EXEC;
            end
            RAS_RD_B: begin
                regnum  = b_num_q;
                opb_d   = regout;
                state_d = RAS_EXEC;
            end
            RAS_EXEC: begin
                ops_valid = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                // A result on the final counted cycle still wins over the timeout.
                if (result_valid) begin
                    res_d   = result;
                    state_d = wr_en_q ? RAS_WB : RAS_DONE;
                end else if (cnt_q == c_tmo_last) begin
                    timeout_d = 1'b1;
                    state_d   = RAS_DONE;
                end
            end
            RAS_WB: begin
                regnum  = wr_num_q;
                regval  = res_q;
                regset  = 1'b1;
                state_d = RAS_DONE;
            end
            RAS_DONE: begin
                done    = 1'b1;
                state_d = RAS_IDLE;
            end
            default: state_d = RAS_IDLE;
        endcase
    end

    assign busy    = (state_q != RAS_IDLE);
    assign opa     = opa_q;
    assign opb     = opb_q;
    assign timeout = timeout_q;

endmodule : reg_access_seq

`default_nettype wire

// File: tb/tb_reg_access_seq.sv
// +----------------------------------------------------------------------------+
// | tb_reg_access_seq : scenario bench with a register-stack model and queue   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reg_access_seq;

    logic        clk = 1'b0;
    logic        do_reset_n = 1'b0;
    logic        start = 1'b0;
    logic        rd_a_en = 1'b0, rd_b_en = 1'b0, wr_en = 1'b0;
    logic [3:0]  rd_a_num = '0, rd_b_num = '0, wr_num = '0;
    logic        result_valid = 1'b0;
    logic [15:0] result = '0;
    logic [15:0] regout;
    logic [3:0]  regnum;
    logic [15:0] regval, opa, opb;
    logic        regset, ops_valid, busy, done, timeout;

    logic [15:0] mem [16];

    typedef struct {
        logic [15:0] opa;
        logic [15:0] opb;
        int          set_n;
        logic [3:0]  set_num;
        logic [15:0] set_val;
        int          lat;
        logic        tmo;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    int          obs_done, obs_lat, obs_set_n, obs_exec;
    logic [3:0]  obs_set_num;
    logic [15:0] obs_set_val, obs_opa, obs_opb;
    logic        obs_tmo;

    reg_access_seq dut (
        .clk(clk), .do_reset_n(do_reset_n), .start(start),
        .rd_a_en(rd_a_en), .rd_a_num(rd_a_num), .rd_b_en(rd_b_en), .rd_b_num(rd_b_num),
        .wr_en(wr_en), .wr_num(wr_num), .result_valid(result_valid), .result(result),
        .regout(regout), .regnum(regnum), .regval(regval), .regset(regset),
        .opa(opa), .opb(opb), .ops_valid(ops_valid), .busy(busy), .done(done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    assign regout = mem[regnum];
    always @(posedge clk) if (regset) mem[regnum] = regval;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input bit a_en, input logic [3:0] a, input bit b_en,
                         input logic [3:0] b, input bit w_en, input logic [3:0] w);
        rd_a_en = a_en; rd_a_num = a; rd_b_en = b_en; rd_b_num = b;
        wr_en = w_en; wr_num = w; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Observes one sequence from the cycle after acceptance; res_at < 0 never answers.
    task automatic collect(input int res_at, input logic [15:0] res, input bit spam);
        obs_done = 0; obs_lat = 0; obs_set_n = 0; obs_exec = 0; obs_tmo = 1'b0;
        obs_set_num = '0; obs_set_val = '0; obs_opa = 16'hDEAD; obs_opb = 16'hDEAD;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (regset) begin obs_set_n++; obs_set_num = regnum; obs_set_val = regval; end
            if (ops_valid) begin obs_opa = opa; obs_opb = opb; end
            if (done) begin obs_done = 1; obs_lat = cyc; obs_tmo = timeout; break; end
            result_valid = ops_valid && (obs_exec == res_at);
            result = res;
            if (ops_valid) obs_exec++;
            if (spam) begin
                start = 1'b1;
                rd_a_en = 1'($urandom_range(0, 1)); rd_b_en = 1'($urandom_range(0, 1));
                wr_en = 1'($urandom_range(0, 1));
                rd_a_num = 4'($urandom_range(0, 15)); rd_b_num = 4'($urandom_range(0, 15));
                wr_num = 4'($urandom_range(0, 15));
            end
            tick();
        end
        result_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_seq(input string nm);
        exp_t e;
        e = sb.pop_front();
        n_cmp++; if (obs_done !== 1) begin n_err++; $display("FAIL %s_done: no done within bound", nm); end
        n_cmp++; if (obs_lat !== e.lat) begin n_err++; $display("FAIL %s_latency: got %0d expected %0d", nm, obs_lat, e.lat); end
        n_cmp++; if (obs_opa !== e.opa) begin n_err++; $display("FAIL %s_opa: got %h expected %h", nm, obs_opa, e.opa); end
        n_cmp++; if (obs_opb !== e.opb) begin n_err++; $display("FAIL %s_opb: got %h expected %h", nm, obs_opb, e.opb); end
        n_cmp++; if (obs_set_n !== e.set_n) begin n_err++; $display("FAIL %s_regset_count: got %0d expected %0d", nm, obs_set_n, e.set_n); end
        n_cmp++; if (obs_set_num !== e.set_num || obs_set_val !== e.set_val) begin
            n_err++; $display("FAIL %s_write: got r%0d=%h expected r%0d=%h", nm, obs_set_num, obs_set_val, e.set_num, e.set_val);
        end
        n_cmp++; if (obs_tmo !== e.tmo) begin n_err++; $display("FAIL %s_timeout: got %b expected %b", nm, obs_tmo, e.tmo); end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h0101);
        do_reset_n = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({busy, done, regset, ops_valid, timeout, regnum, regval, opa, opb} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got busy=%b done=%b regset=%b ov=%b tmo=%b rn=%h rv=%h opa=%h opb=%h expected all zero",
                              busy, done, regset, ops_valid, timeout, regnum, regval, opa, opb);
        end
        @(negedge clk); do_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_full_path();
        mem[2] = 16'h1234; mem[3] = 16'h0042;
        sb.push_back('{opa: 16'h1234, opb: 16'h0042, set_n: 1, set_num: 4'd5, set_val: 16'h1276, lat: 5, tmo: 1'b0});
        issue(1, 4'd2, 1, 4'd3, 1, 4'd5);
        collect(0, 16'h1276, 0);
        check_seq("full");
        n_cmp++; if (mem[5] !== 16'h1276) begin n_err++; $display("FAIL full_mem5: got %h expected 1276", mem[5]); end
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL full_idle: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_no_reads();
        sb.push_back('{opa: 16'h0, opb: 16'h0, set_n: 0, set_num: 4'd0, set_val: 16'h0, lat: 5, tmo: 1'b0});
        issue(0, 4'd2, 0, 4'd3, 0, 4'd7);
        collect(3, 16'hCAFE, 0);
        check_seq("noread");
        tick();
    endtask

    task automatic test_timeout();
        sb.push_back('{opa: 16'h0, opb: 16'h0, set_n: 0, set_num: 4'd0, set_val: 16'h0, lat: 16, tmo: 1'b1});
        issue(0, 4'd0, 0, 4'd0, 1, 4'd9);
        collect(-1, 16'h0, 0);
        check_seq("tmo");
        n_cmp++; if (obs_exec !== 15) begin n_err++; $display("FAIL tmo_exec_cycles: got %0d expected 15", obs_exec); end
        tick();
        n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL tmo_held: got %b expected 1", timeout); end
        sb.push_back('{opa: 16'h0, opb: 16'h0, set_n: 0, set_num: 4'd0, set_val: 16'h0, lat: 2, tmo: 1'b0});
        issue(0, 4'd0, 0, 4'd0, 0, 4'd0);
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL tmo_cleared: got %b expected 0", timeout); end
        collect(0, 16'h0, 0);
        check_seq("tmo_next");
        tick();
    endtask

    task automatic test_back_to_back();
        int extra;
        mem[6] = 16'h00AA; mem[7] = 16'h0055;
        sb.push_back('{opa: 16'h00AA, opb: 16'h0055, set_n: 1, set_num: 4'd8, set_val: 16'hBEEF, lat: 6, tmo: 1'b0});
        issue(1, 4'd6, 1, 4'd7, 1, 4'd8);
        collect(1, 16'hBEEF, 1);
        check_seq("spam");
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL spam_extra_activity: got %0d busy/done cycles expected 0", extra); end
    endtask

    task automatic test_same_reg();
        mem[4] = 16'h0007;
        sb.push_back('{opa: 16'h0007, opb: 16'h0007, set_n: 1, set_num: 4'd4, set_val: 16'h000E, lat: 5, tmo: 1'b0});
        issue(1, 4'd4, 1, 4'd4, 1, 4'd4);
        collect(0, 16'h000E, 0);
        check_seq("same");
        n_cmp++; if (mem[4] !== 16'h000E) begin n_err++; $display("FAIL same_mem4: got %h expected 000e", mem[4]); end
        tick();
    endtask

    task automatic test_reset_in_wb();
        int seen;
        mem[9] = 16'h1111; mem[10] = 16'h2222;
        issue(1, 4'd9, 0, 4'd0, 1, 4'd10);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (regset) begin seen = 1; break; end
            result_valid = ops_valid; result = 16'h3333;
            tick();
        end
        result_valid = 1'b0;
        n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL rst_wb_reached: got %0d expected 1", seen); end
        #2 do_reset_n = 1'b0;
        #1;
        n_cmp++; if ({regset, busy, done} !== 3'b000) begin
            n_err++; $display("FAIL rst_wb_async: got regset=%b busy=%b done=%b expected 000", regset, busy, done);
        end
        tick();
        n_cmp++; if (mem[10] !== 16'h2222) begin n_err++; $display("FAIL rst_wb_no_write: got %h expected 2222", mem[10]); end
        @(negedge clk); do_reset_n = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_wb_idle: got busy=%b expected 0", busy); end
        sb.push_back('{opa: 16'h0, opb: 16'h1111, set_n: 1, set_num: 4'd11, set_val: 16'h4444, lat: 6, tmo: 1'b0});
        issue(0, 4'd0, 1, 4'd9, 1, 4'd11);
        collect(2, 16'h4444, 0);
        check_seq("after_rst");
        tick();
    endtask

    initial begin
        test_reset();
        test_full_path();
        test_no_reads();
        test_timeout();
        test_back_to_back();
        test_same_reg();
        test_reset_in_wb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_access_seq

`default_nettype wire
